// File: rtl/tw_rom_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tw_rom_seq_ctrl
//
// Sequencer between the top-level NTT controller and the twiddle ROM.
//   * Collects 2*ENTRIES config half-words from a valid/ready stream into a
//     local ENTRIES x (2*DW) buffer.
//   * Bursts that buffer into the ROM stage-0 bank: all hi halves on rom_w=1,
//     then all lo halves on rom_w=2, on contiguous cycles.
//   * Runs the twiddle schedule: NUM_STAGES stages, each holding CEN low for
//     its programmed length, separated by one-cycle gaps, ending with a
//     one-cycle done pulse.
//
// Handshake: a config word is transferred on every rising CLK edge where
//   cfg_valid && cfg_ready. cfg_ready is only ever high in COLLECT; the
//   producer may hold or drop cfg_valid freely, and cfg_data must be stable
//   while cfg_valid is high. Words offered while cfg_ready is low are ignored.
//
// Ports
//   CLK, rst_n            clock (rising edge), async active-low reset
//   load_req              pulse, start collecting a new stage-0 table
//   cfg_valid/cfg_ready   config stream handshake
//   cfg_data [DW]         half-words in order e0.hi, e0.lo, e1.hi, ... e3.lo
//   start                 pulse, run all stages
//   busy                  high in any state but IDLE
//   done                  one-cycle pulse at end of a run
//   rom_cen               ROM chip enable, active low
//   rom_stage_counter[3]  ROM stage_counter
//   rom_state [4]         RUN_STATE while running, else 0
//   rom_w [2]             0 idle, 1 hi-half write, 2 lo-half write
//   rom_hdata [DW]        ROM horizontal_data_in
//
// Every output is a register loaded from the next-state decode, so each
// output reflects the state the FSM is in during that same cycle.
// ---------------------------------------------------------------------------
module tw_rom_seq_ctrl #(
  parameter int         DW         = 64,
  parameter int         ENTRIES    = 4,
  parameter int         NUM_STAGES = 3,
  parameter int         LEN_W      = 11,
  parameter int         STAGE0_LEN = 16,
  parameter int         STAGE1_LEN = 1024,
  parameter int         STAGE2_LEN = 4,
  parameter logic [3:0] RUN_STATE  = 4'd4
) (
  input  logic          CLK,
  input  logic          rst_n,
  input  logic          load_req,
  input  logic          cfg_valid,
  input  logic [DW-1:0] cfg_data,
  output logic          cfg_ready,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          rom_cen,
  output logic [2:0]    rom_stage_counter,
  output logic [3:0]    rom_state,
  output logic [1:0]    rom_w,
  output logic [DW-1:0] rom_hdata
);

  localparam int IDX_W = $clog2(2 * ENTRIES);
  localparam int K_W   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(2 * ENTRIES - 1);
  localparam logic [K_W-1:0]   K_LAST     = K_W'(ENTRIES - 1);
  localparam logic [2:0]       STAGE_LAST = 3'(NUM_STAGES - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    COLLECT  = 3'd1,
    BURST_HI = 3'd2,
    BURST_LO = 3'd3,
    RUN      = 3'd4,
    GAP      = 3'd5,
    FIN      = 3'd6
  } state_t;

  state_t state, state_d;

  logic [IDX_W-1:0] idx, idx_d;        // accepted word count in COLLECT
  logic [K_W-1:0]   k, k_d;            // entry index being written in a burst
  logic [2:0]       stage, stage_d;
  logic [LEN_W-1:0] len_cnt, len_d;
  logic [LEN_W-1:0] cur_len;

  logic [DW-1:0]    buf_hi [ENTRIES];
  logic [DW-1:0]    buf_lo [ENTRIES];

  logic             accept;

  // Next-cycle values of the registered outputs
  logic             cfg_ready_d, busy_d, done_d, rom_cen_d;
  logic [2:0]       rom_stage_d;
  logic [3:0]       rom_state_d;
  logic [1:0]       rom_w_d;
  logic [DW-1:0]    rom_hdata_d;

  function automatic logic [LEN_W-1:0] stage_len(input logic [2:0] s);
    case (s)
      3'd0:    stage_len = LEN_W'(STAGE0_LEN);
      3'd1:    stage_len = LEN_W'(STAGE1_LEN);
      default: stage_len = LEN_W'(STAGE2_LEN);
    endcase
  endfunction

  assign cur_len = stage_len(stage);
  assign accept  = (state == COLLECT) && cfg_valid && cfg_ready;

  // ---------------------------------------------------------------------
  // State and counter registers
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      k       <= '0;
      stage   <= '0;
      len_cnt <= '0;
    end else begin
      state   <= state_d;
      idx     <= idx_d;
      k       <= k_d;
      stage   <= stage_d;
      len_cnt <= len_d;
    end
  end

  // ---------------------------------------------------------------------
  // Config buffer: even word index is the hi half, odd is the lo half
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        buf_hi[i] <= '0;
        buf_lo[i] <= '0;
      end
    end else if (accept) begin
      if (idx[0]) buf_lo[idx >> 1] <= cfg_data;
      else        buf_hi[idx >> 1] <= cfg_data;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state and next-output decode
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state;
    idx_d   = idx;
    k_d     = k;
    stage_d = stage;
    len_d   = len_cnt;

    case (state)
      IDLE: begin
        // load_req has priority; a simultaneous start is dropped
        if (load_req) begin
          state_d = COLLECT;
          idx_d   = '0;
        end else if (start) begin
          state_d = RUN;
          stage_d = '0;
          len_d   = '0;
        end
      end

      COLLECT: begin
        if (accept) begin
          idx_d = idx + 1'b1;
          if (idx == IDX_LAST) begin
            state_d = BURST_HI;
            idx_d   = '0;
            k_d     = '0;
          end
        end
      end

      // The ROM's own 2-bit write index wraps between halves, so the hi
      // and lo bursts must follow each other with no idle cycle.
      BURST_HI: begin
        if (k == K_LAST) begin
          state_d = BURST_LO;
          k_d     = '0;
        end else begin
          k_d = k + 1'b1;
        end
      end

      BURST_LO: begin
        if (k == K_LAST) begin
          state_d = IDLE;
          k_d     = '0;
        end else begin
          k_d = k + 1'b1;
        end
      end

      RUN: begin
        // Length counter stops at LEN-1; it never wraps
        if (len_cnt == cur_len - LEN_W'(1)) begin
          state_d = (stage == STAGE_LAST) ? FIN : GAP;
        end else begin
          len_d = len_cnt + 1'b1;
        end
      end

      GAP: begin
        state_d = RUN;
        stage_d = stage + 1'b1;
        len_d   = '0;
      end

      FIN: begin
        state_d = IDLE;
        stage_d = '0;
        len_d   = '0;
      end

      default: state_d = IDLE;
    endcase

    // Outputs follow the state being entered
    cfg_ready_d = (state_d == COLLECT);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == FIN);
    rom_cen_d   = (state_d != RUN);
    rom_state_d = (state_d == RUN) ? RUN_STATE : 4'd0;
    rom_stage_d = ((state_d == RUN) || (state_d == GAP)) ? stage_d : 3'd0;
    rom_w_d     = 2'd0;
    rom_hdata_d = '0;
    if (state_d == BURST_HI) begin
      rom_w_d     = 2'd1;
      rom_hdata_d = buf_hi[k_d];
    end else if (state_d == BURST_LO) begin
      rom_w_d     = 2'd2;
      rom_hdata_d = buf_lo[k_d];
    end
  end

  // ---------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      cfg_ready         <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      rom_cen           <= 1'b1;
      rom_stage_counter <= 3'd0;
      rom_state         <= 4'd0;
      rom_w             <= 2'd0;
      rom_hdata         <= '0;
    end else begin
      cfg_ready         <= cfg_ready_d;
      busy              <= busy_d;
      done              <= done_d;
      rom_cen           <= rom_cen_d;
      rom_stage_counter <= rom_stage_d;
      rom_state         <= rom_state_d;
      rom_w             <= rom_w_d;
      rom_hdata         <= rom_hdata_d;
    end
  end

endmodule

// File: tb/tb_tw_rom_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tw_rom_seq_ctrl
//
// Directed sequence with randomized data, cfg_valid gaps and stray requests.
// The run schedule is predicted from the stage lengths alone and each cycle
// is checked against that expected trace. Loads are checked against the word
// order rule and against a small model of the ROM's wrapping write index.
// ---------------------------------------------------------------------------
module tb_tw_rom_seq_ctrl;

  localparam int DW = 64;

  // ---------------- clock / reset ----------------
  logic          CLK = 1'b0;
  logic          rst_n = 1'b1;
  logic          load_req = 1'b0;
  logic          cfg_valid = 1'b0;
  logic [DW-1:0] cfg_data = '0;
  logic          start = 1'b0;
  logic          cfg_ready, busy, done, rom_cen;
  logic [2:0]    rom_stage_counter;
  logic [3:0]    rom_state;
  logic [1:0]    rom_w;
  logic [DW-1:0] rom_hdata;

  always #5 CLK = ~CLK;

  tw_rom_seq_ctrl dut (
    .CLK               (CLK),
    .rst_n             (rst_n),
    .load_req          (load_req),
    .cfg_valid         (cfg_valid),
    .cfg_data          (cfg_data),
    .cfg_ready         (cfg_ready),
    .start             (start),
    .busy              (busy),
    .done              (done),
    .rom_cen           (rom_cen),
    .rom_stage_counter (rom_stage_counter),
    .rom_state         (rom_state),
    .rom_w             (rom_w),
    .rom_hdata         (rom_hdata)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [DW-1:0] words [8];

  // Observed ROM writes: strobe, data, cycle number
  logic [1:0]    wq_w [$];
  logic [DW-1:0] wq_d [$];
  int            wq_c [$];

  // Expected run trace, one entry per cycle:
  // [10] busy [9] check stage [8] done [7] cen [6:4] stage [3:0] rom_state
  logic [10:0] exp_q [$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write monitor
  always @(posedge CLK) begin
    cyc++;
    #1;
    if (rom_w != 2'd0) begin
      wq_w.push_back(rom_w);
      wq_d.push_back(rom_hdata);
      wq_c.push_back(cyc);
    end
  end

  // ---------------- driver tasks ----------------
  // mode 0: cfg_valid always high, 1: toggles every cycle, 2: random gaps
  task automatic do_load(input int mode, input bit with_start);
    int n, guard;
    bit rdy, v;
    logic [1:0]    ri;
    logic [DW-1:0] mhi [4];
    logic [DW-1:0] mlo [4];
    wq_w.delete(); wq_d.delete(); wq_c.delete();
    @(negedge CLK);
    load_req = 1'b1;
    start    = with_start;
    @(posedge CLK); #1;
    load_req = 1'b0;
    start    = 1'b0;
    chk("load_busy",  busy, 1);
    chk("load_ready", cfg_ready, 1);
    chk("load_cen",   rom_cen, 1);
    n = 0;
    guard = 0;
    while (n < 8 && guard < 200) begin
      @(negedge CLK);
      rdy = cfg_ready;
      case (mode)
        0:       v = 1'b1;
        1:       v = (guard % 2 == 0);
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      cfg_valid = v;
      cfg_data  = v ? words[n] : {$urandom, $urandom};
      @(posedge CLK);
      if (v && rdy) n++;
      guard++;
    end
    chk("load_accepts", n, 8);
    @(negedge CLK);
    chk("ready_drop", cfg_ready, 0);
    // Stray words during the burst must be ignored
    cfg_valid = (mode == 2);
    cfg_data  = {$urandom, $urandom};
    repeat (12) @(negedge CLK);
    cfg_valid = 1'b0;
    chk("burst_len", wq_w.size(), 8);
    if (wq_w.size() == 8) begin
      for (int j = 0; j < 8; j++) begin
        chk("burst_w",    wq_w[j], (j < 4) ? 2'd1 : 2'd2);
        chk("burst_data", wq_d[j], (j < 4) ? words[2 * j] : words[2 * (j - 4) + 1]);
        chk("burst_contig", wq_c[j] - wq_c[0], j);
      end
      // ROM stage-0 bank: one wrapping 2-bit index shared by both halves
      ri = 2'd0;
      for (int j = 0; j < 8; j++) begin
        if (wq_w[j] == 2'd1) mhi[ri] = wq_d[j];
        else                 mlo[ri] = wq_d[j];
        ri = ri + 2'd1;
      end
      chk("rom_entry1", {mhi[1], mlo[1]}, {words[2], words[3]});
      chk("rom_entry3", {mhi[3], mlo[3]}, {words[6], words[7]});
    end
    chk("load_end_busy", busy, 0);
    chk("load_end_cen",  rom_cen, 1);
  endtask

  // Runs one schedule; abort_at >= 0 pulls reset at that cycle index,
  // noise injects a stray start and load_req mid-run.
  task automatic run_sched(input int abort_at, input bit noise);
    int lens [3];
    logic [10:0] e;
    int i, ns, nl;
    lens[0] = 16; lens[1] = 1024; lens[2] = 4;
    exp_q.delete();
    for (int s = 0; s < 3; s++) begin
      repeat (lens[s]) exp_q.push_back({1'b1, 1'b1, 1'b0, 1'b0, 3'(s), 4'd4});
      if (s < 2) exp_q.push_back({1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 4'd0});
    end
    exp_q.push_back({1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 4'd0});   // finish
    exp_q.push_back({1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 4'd0});   // back to idle
    ns = noise ? $urandom_range(1, 1040) : -1;
    nl = noise ? $urandom_range(1, 1040) : -1;
    @(negedge CLK);
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("run_cen",   rom_cen, e[7]);
      chk("run_done",  done, e[8]);
      chk("run_state", rom_state, e[3:0]);
      chk("run_busy",  busy, e[10]);
      chk("run_ready", cfg_ready, 0);
      chk("run_w",     rom_w, 0);
      if (e[9]) chk("run_stage", rom_stage_counter, e[6:4]);
      if (i == abort_at) begin
        #1 rst_n = 1'b0;
        #1;
        chk("abort_cen",   rom_cen, 1);
        chk("abort_busy",  busy, 0);
        chk("abort_done",  done, 0);
        chk("abort_state", rom_state, 0);
        chk("abort_stage", rom_stage_counter, 0);
        @(negedge CLK);
        rst_n = 1'b1;
        exp_q.delete();
        break;
      end
      start     = (i == ns);
      load_req  = (i == nl);
      cfg_valid = (i == nl);
      @(posedge CLK); #1;
      i++;
    end
    start     = 1'b0;
    load_req  = 1'b0;
    cfg_valid = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_cen",   rom_cen, 1);
    chk("rst_busy",  busy, 0);
    chk("rst_done",  done, 0);
    chk("rst_ready", cfg_ready, 0);
    chk("rst_w",     rom_w, 0);
    chk("rst_stage", rom_stage_counter, 0);
    chk("rst_state", rom_state, 0);
    chk("rst_hdata", rom_hdata, 0);
    @(negedge CLK);
    rst_n = 1'b1;

    // Idle with stray config words
    repeat (10) begin
      @(negedge CLK);
      cfg_valid = 1'b1;
      cfg_data  = {$urandom, $urandom};
      @(posedge CLK); #1;
      chk("idle_cen",   rom_cen, 1);
      chk("idle_w",     rom_w, 0);
      chk("idle_busy",  busy, 0);
      chk("idle_ready", cfg_ready, 0);
    end
    cfg_valid = 1'b0;

    // Known table, no gaps, then valid toggling
    for (int j = 0; j < 8; j++) words[j] = DW'(8'h11 + j);
    do_load(0, 1'b0);
    do_load(1, 1'b0);

    // Random table with random gaps
    for (int j = 0; j < 8; j++) words[j] = {$urandom, $urandom};
    do_load(2, 1'b0);

    // Full schedule
    run_sched(-1, 1'b0);

    // start together with load_req: load wins, start dropped
    for (int j = 0; j < 8; j++) words[j] = {$urandom, $urandom};
    do_load(0, 1'b1);
    repeat (3) begin
      @(posedge CLK); #1;
      chk("drop_start_cen", rom_cen, 1);
    end

    // Stray start and load_req during a run
    run_sched(-1, 1'b1);

    // Reset at stage-1 cycle 500, then a fresh full run
    run_sched(16 + 1 + 500, 1'b0);
    run_sched(-1, 1'b0);

    for (int j = 0; j < 8; j++) words[j] = {$urandom, $urandom};
    do_load(2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
